// File: rtl/qbus_burst_master.sv
// -----------------------------------------------------------------------------
// qbus_burst_master
//   QBUS DMA bus master. Arbitrates for the bus (TDMR/RDMGI/TSACK), runs one
//   DATI or DATO bus cycle per word, and either re-arbitrates after every word
//   or, in block mode, streams up to BURST_MAX words within one TSYNC cycle.
//   A slave that never answers with RRPLY within NXM_TIMEOUT clocks of
//   TDIN/TDOUT is treated as non-existent memory. When that happens, nxm is
//   set and the request is abandoned.
//
//   Configuration macro: QBUS_BLOCK_MODE_EN
//     defined   - block mode. GAP loops back to DATA while the slave keeps
//                 RBS7 high. TWTBT also flags block reads during ADDR.
//     undefined - one word per bus cycle. BURST_MAX and RBS7 have no effect.
//
// Ports
//   qclk, reset_n          clock (20 MHz) and asynchronous active-low reset
//   RSYNC..RBS7            received QBUS lines, asserted-high
//   TSYNC..TWTBT           QBUS driver enables, asserted-high
//   dma_start/write/addr/wc  request: pulse, direction (1=DATO), byte address,
//                          word count (0 = no transfer)
//   cur_addr               address of the word currently on the bus
//   assert_addr/data       datapath drives cur_addr / write word onto DAL
//   read_pulse             capture the DAL read word
//   word_done              one pulse per completed word
//   bus_master             follows TSACK
//   busy                   request in progress
//   dma_complete           end-of-request pulse
//   nxm                    sticky timeout flag
//   All outputs are registered. They are decoded from the next-state values.
// -----------------------------------------------------------------------------
module qbus_burst_master #(
    parameter int WC_W        = 16,
    parameter int BURST_MAX   = 16,
    parameter int ADDR_SETUP  = 3,
    parameter int NXM_TIMEOUT = 200
) (
    input  logic            qclk,
    input  logic            reset_n,
    input  logic            RSYNC,
    input  logic            RRPLY,
    input  logic            RDMR,
    input  logic            RSACK,
    input  logic            RINIT,
    input  logic            RDMGI,
    input  logic            RBS7,
    output logic            TSYNC,
    output logic            TDIN,
    output logic            TDOUT,
    output logic            TDMR,
    output logic            TSACK,
    output logic            TDMGO,
    output logic            TWTBT,
    input  logic            dma_start,
    input  logic            dma_write,
    input  logic [21:0]     dma_addr,
    input  logic [WC_W-1:0] dma_wc,
    output logic [21:0]     cur_addr,
    output logic            assert_addr,
    output logic            assert_data,
    output logic            read_pulse,
    output logic            word_done,
    output logic            bus_master,
    output logic            busy,
    output logic            dma_complete,
    output logic            nxm
);

`ifdef QBUS_BLOCK_MODE_EN
    localparam logic BLOCK_EN = 1'b1;
`else
    localparam logic BLOCK_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(NXM_TIMEOUT + ADDR_SETUP + 1) + 1;
    localparam int BC_W  = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_GRANT = 3'd2,
        ST_ADDR  = 3'd3,
        ST_SYNC  = 3'd4,
        ST_DATA  = 3'd5,
        ST_GAP   = 3'd6,
        ST_REL   = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic              dir_q, dir_d;
    logic [21:0]       cur_addr_q, cur_addr_d;
    logic [WC_W-1:0]   wc_q, wc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // strobe phase of DATA: TDIN/TDOUT driven, nxm timer running
    logic              strobe_q, strobe_d;
    logic [BC_W-1:0]   burst_q, burst_d;
    logic              bs7_q, bs7_d;
    logic              nxm_q, nxm_d;

    logic tsync_q, tsync_d, tdin_q, tdin_d, tdout_q, tdout_d;
    logic tdmr_q, tdmr_d, tsack_q, tsack_d, tdmgo_q, tdmgo_d, twtbt_q, twtbt_d;
    logic assert_addr_q, assert_addr_d, assert_data_q, assert_data_d;
    logic read_pulse_q, read_pulse_d, word_done_q, word_done_d;
    logic busy_q, busy_d, dma_complete_q, dma_complete_d;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d        = state_q;
        dir_d          = dir_q;
        cur_addr_d     = cur_addr_q;
        wc_d           = wc_q;
        cnt_d          = cnt_q;
        strobe_d       = strobe_q;
        burst_d        = burst_q;
        bs7_d          = bs7_q;
        nxm_d          = nxm_q;
        read_pulse_d   = 1'b0;
        word_done_d    = 1'b0;
        dma_complete_d = 1'b0;

        if (RINIT) begin
            // Bus init aborts everything silently; no completion pulse.
            state_d  = ST_IDLE;
            wc_d     = '0;
            cnt_d    = '0;
            strobe_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dma_start && !busy_q) begin
                        if (dma_wc != '0) begin
                            dir_d      = dma_write;
                            cur_addr_d = {dma_addr[21:1], 1'b0};
                            wc_d       = dma_wc;
                            nxm_d      = 1'b0;
                            state_d    = ST_REQ;
                        end else begin
                            dma_complete_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (RDMGI && !RSACK) begin
                        state_d = ST_GRANT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_GRANT: begin
                    // Previous bus cycle must be fully finished before taking over.
                    if (!RSYNC && !RRPLY) begin
                        state_d = ST_ADDR;
                        cnt_d   = '0;
                        burst_d = '0;
                    end else begin
                        state_d = ST_GRANT;
                    end
                end
                ST_ADDR: begin
                    if (cnt_q == CNT_W'(ADDR_SETUP - 1)) begin
                        state_d = ST_SYNC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_SYNC: begin
                    // Reads strobe at once; writes first set up data on DAL.
                    state_d  = ST_DATA;
                    cnt_d    = '0;
                    strobe_d = ~dir_q;
                end
                ST_DATA: begin
                    if (!strobe_q) begin
                        if (cnt_q == CNT_W'(ADDR_SETUP - 1)) begin
                            strobe_d = 1'b1;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (RRPLY) begin
                        read_pulse_d = ~dir_q;
                        word_done_d  = 1'b1;
                        bs7_d        = RBS7;
                        strobe_d     = 1'b0;
                        cnt_d        = '0;
                        state_d      = ST_GAP;
                    end else if (cnt_q == CNT_W'(NXM_TIMEOUT - 1)) begin
                        // No slave answered: give up on the whole request.
                        nxm_d    = 1'b1;
                        wc_d     = '0;
                        strobe_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = ST_REL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (!RRPLY) begin
                        cur_addr_d = cur_addr_q + 22'd2;
                        wc_d       = wc_q - WC_W'(1);
                        if (wc_q == WC_W'(1)) begin
                            state_d = ST_REL;
                        end else if (BLOCK_EN && bs7_q &&
                                     (burst_q < BC_W'(BURST_MAX - 1))) begin
                            state_d  = ST_DATA;
                            burst_d  = burst_q + BC_W'(1);
                            strobe_d = ~dir_q;
                            cnt_d    = '0;
                        end else begin
                            state_d = ST_REL;
                        end
                    end else begin
                        state_d = ST_GAP;
                    end
                end
                ST_REL: begin
                    if (wc_q != '0) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d        = ST_IDLE;
                        dma_complete_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        tdmr_d        = (state_d == ST_REQ);
        tsack_d       = (state_d inside {ST_GRANT, ST_ADDR, ST_SYNC, ST_DATA, ST_GAP});
        tsync_d       = (state_d inside {ST_SYNC, ST_DATA, ST_GAP});
        tdin_d        = (state_d == ST_DATA) && !dir_d && strobe_d;
        tdout_d       = (state_d == ST_DATA) && dir_d && strobe_d;
        assert_addr_d = (state_d inside {ST_ADDR, ST_SYNC});
        assert_data_d = (state_d == ST_DATA) && dir_d;
        twtbt_d       = (dir_d && (state_d inside {ST_ADDR, ST_SYNC, ST_DATA, ST_GAP})) ||
                        (BLOCK_EN && !dir_d && (state_d == ST_ADDR));
        // The grant is forwarded down the chain only when it is not ours.
        tdmgo_d       = RDMGI && (state_q != ST_REQ) && (state_d != ST_REQ) && !RINIT;
        busy_d        = (state_d != ST_IDLE) || dma_complete_d;
    end

    // State, datapath and output registers
    always_ff @(posedge qclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            dir_q          <= 1'b0;
            cur_addr_q     <= 22'd0;
            wc_q           <= '0;
            cnt_q          <= '0;
            strobe_q       <= 1'b0;
            burst_q        <= '0;
            bs7_q          <= 1'b0;
            nxm_q          <= 1'b0;
            tsync_q        <= 1'b0;
            tdin_q         <= 1'b0;
            tdout_q        <= 1'b0;
            tdmr_q         <= 1'b0;
            tsack_q        <= 1'b0;
            tdmgo_q        <= 1'b0;
            twtbt_q        <= 1'b0;
            assert_addr_q  <= 1'b0;
            assert_data_q  <= 1'b0;
            read_pulse_q   <= 1'b0;
            word_done_q    <= 1'b0;
            busy_q         <= 1'b0;
            dma_complete_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            dir_q          <= dir_d;
            cur_addr_q     <= cur_addr_d;
            wc_q           <= wc_d;
            cnt_q          <= cnt_d;
            strobe_q       <= strobe_d;
            burst_q        <= burst_d;
            bs7_q          <= bs7_d;
            nxm_q          <= nxm_d;
            tsync_q        <= tsync_d;
            tdin_q         <= tdin_d;
            tdout_q        <= tdout_d;
            tdmr_q         <= tdmr_d;
            tsack_q        <= tsack_d;
            tdmgo_q        <= tdmgo_d;
            twtbt_q        <= twtbt_d;
            assert_addr_q  <= assert_addr_d;
            assert_data_q  <= assert_data_d;
            read_pulse_q   <= read_pulse_d;
            word_done_q    <= word_done_d;
            busy_q         <= busy_d;
            dma_complete_q <= dma_complete_d;
        end
    end

    assign TSYNC        = tsync_q;
    assign TDIN         = tdin_q;
    assign TDOUT        = tdout_q;
    assign TDMR         = tdmr_q;
    assign TSACK        = tsack_q;
    assign TDMGO        = tdmgo_q;
    assign TWTBT        = twtbt_q;
    assign cur_addr     = cur_addr_q;
    assign assert_addr  = assert_addr_q;
    assign assert_data  = assert_data_q;
    assign read_pulse   = read_pulse_q;
    assign word_done    = word_done_q;
    assign bus_master   = tsack_q;
    assign busy         = busy_q;
    assign dma_complete = dma_complete_q;
    assign nxm          = nxm_q;

    // RDMR is informational only; another master's request never blocks ours.
    logic rdmr_unused_s;
    assign rdmr_unused_s = RDMR;

endmodule

// File: tb/tb_qbus_burst_master.sv
module tb_qbus_burst_master;

    localparam int NXM_TIMEOUT = 200;
    localparam int REPLY_CYC   = 6;
`ifdef QBUS_BLOCK_MODE_EN
    localparam int WR20_SYNCS = 2;
`else
    localparam int WR20_SYNCS = 20;
`endif

    logic qclk = 1'b0;
    logic reset_n;
    logic RSYNC, RRPLY, RDMR, RSACK, RINIT, RDMGI, RBS7;
    logic TSYNC, TDIN, TDOUT, TDMR, TSACK, TDMGO, TWTBT;
    logic dma_start, dma_write;
    logic [21:0] dma_addr;
    logic [15:0] dma_wc;
    logic [21:0] cur_addr;
    logic assert_addr, assert_data, read_pulse, word_done;
    logic bus_master, busy, dma_complete, nxm;

    qbus_burst_master #(
        .WC_W(16), .BURST_MAX(16), .ADDR_SETUP(3), .NXM_TIMEOUT(NXM_TIMEOUT)
    ) dut (
        .qclk(qclk), .reset_n(reset_n),
        .RSYNC(RSYNC), .RRPLY(RRPLY), .RDMR(RDMR), .RSACK(RSACK),
        .RINIT(RINIT), .RDMGI(RDMGI), .RBS7(RBS7),
        .TSYNC(TSYNC), .TDIN(TDIN), .TDOUT(TDOUT), .TDMR(TDMR),
        .TSACK(TSACK), .TDMGO(TDMGO), .TWTBT(TWTBT),
        .dma_start(dma_start), .dma_write(dma_write),
        .dma_addr(dma_addr), .dma_wc(dma_wc),
        .cur_addr(cur_addr), .assert_addr(assert_addr),
        .assert_data(assert_data), .read_pulse(read_pulse),
        .word_done(word_done), .bus_master(bus_master), .busy(busy),
        .dma_complete(dma_complete), .nxm(nxm)
    );

    initial forever #25 qclk = ~qclk;

    typedef struct {
        bit          is_cmp;
        logic [21:0] addr;
        bit          rd;
        bit          nxm;
        int          syncs;
        bit          chk_addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   slave_en = 1'b1;
    bit   bs7_en = 1'b0;
    bit   force_dmgi = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arbiter and slave model: grant follows TDMR, reply REPLY_CYC after strobe.
    initial begin
        int dly;
        dly = 0;
        RSYNC = 1'b0; RRPLY = 1'b0; RDMR = 1'b0; RSACK = 1'b0; RDMGI = 1'b0; RBS7 = 1'b0;
        forever begin
            @(negedge qclk);
            RDMGI = (TDMR && !TSACK) || force_dmgi;
            if (slave_en && (TDIN || TDOUT)) begin
                if (dly >= REPLY_CYC - 1) RRPLY = 1'b1;
                else dly++;
            end else begin
                dly   = 0;
                RRPLY = 1'b0;
            end
            RBS7 = RRPLY && bs7_en;
        end
    end

    // Monitor: pops the scoreboard on every word_done / dma_complete.
    initial begin
        exp_t e;
        int   sync_cnt;
        bit   tsync_prev;
        sync_cnt   = 0;
        tsync_prev = 1'b0;
        forever begin
            @(negedge qclk);
            if (TSYNC && !tsync_prev) sync_cnt++;
            tsync_prev = TSYNC;
            if (word_done) begin
                check("word_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("word_kind", e.is_cmp, 0);
                    check("word_addr", cur_addr, e.addr);
                    check("read_pulse", read_pulse, e.rd);
                end
            end
            if (dma_complete) begin
                check("complete_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("complete_kind", e.is_cmp, 1);
                    check("nxm", nxm, e.nxm);
                    check("sync_cycles", sync_cnt, e.syncs);
                    check("busy_at_complete", busy, 1);
                    if (e.chk_addr) check("final_addr", cur_addr, e.addr);
                end
                sync_cnt = 0;
            end else if (!busy) begin
                sync_cnt = 0;
            end
        end
    end

    task automatic start(input bit wr, input logic [21:0] addr, input logic [15:0] wc);
        @(negedge qclk);
        dma_start = 1'b1; dma_write = wr; dma_addr = addr; dma_wc = wc;
        @(negedge qclk);
        dma_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge qclk);
            if (!busy) done = 1'b1;
        end
        check(name, done, 1);
    endtask

    task automatic run_xfer(input string name, input bit wr, input logic [21:0] addr,
                            input int wc, input int syncs);
        exp_t        e;
        logic [21:0] a;
        a = {addr[21:1], 1'b0};
        for (int i = 0; i < wc; i++) begin
            e = '{is_cmp: 1'b0, addr: a, rd: !wr, nxm: 1'b0, syncs: 0, chk_addr: 1'b1};
            exp_q.push_back(e);
            a = a + 22'd2;
        end
        e = '{is_cmp: 1'b1, addr: a, rd: 1'b0, nxm: 1'b0, syncs: syncs, chk_addr: (wc != 0)};
        exp_q.push_back(e);
        start(wr, addr, 16'(wc));
        wait_idle(name, 5000);
    endtask

    initial begin
        exp_t e;
        int   t_in, t_nxm;
        bit   tsync_at, tsack_at, seen;
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   t_in, t_nxm;
        logic tsync_at, tsack_at;
        bit   seen;

        reset_n = 1'b0; RINIT = 1'b0;
        dma_start = 1'b0; dma_write = 1'b0; dma_addr = 22'd0; dma_wc = 16'd0;
        repeat (3) @(negedge qclk);
        check("reset_outputs",
              {TSYNC, TDIN, TDOUT, TDMR, TSACK, TDMGO, TWTBT, assert_addr, assert_data,
               read_pulse, word_done, bus_master, busy, dma_complete, nxm}, 0);
        check("reset_cur_addr", cur_addr, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge qclk);

        // Grant daisy-chain passthrough while idle
        force_dmgi = 1'b1;
        repeat (3) @(negedge qclk);
        check("tdmgo_pass", TDMGO, 1);
        force_dmgi = 1'b0;
        repeat (3) @(negedge qclk);
        check("tdmgo_drop", TDMGO, 0);

        // Single read at 0o1000
        run_xfer("read_1000", 1'b0, 22'o1000, 1, 1);

        // 20-word write, slave signals block mode capability
        bs7_en = 1'b1;
        run_xfer("write_20", 1'b1, 22'h002000, 20, WR20_SYNCS);
        bs7_en = 1'b0;

        // Zero word count: completion pulse only
        run_xfer("wc_zero", 1'b0, 22'h000040, 0, 0);

        // Address wrap
        run_xfer("wrap", 1'b0, 22'h3FFFFE, 2, 2);

        // Non-existent memory timeout
        slave_en = 1'b0;
        e = '{is_cmp: 1'b1, addr: 22'h001230, rd: 1'b0, nxm: 1'b1, syncs: 1, chk_addr: 1'b1};
        exp_q.push_back(e);
        start(1'b0, 22'h001230, 16'd3);
        t_in = -1; t_nxm = -1; tsync_at = 1'b1; tsack_at = 1'b1;
        for (int i = 0; i < 1000 && t_nxm < 0; i++) begin
            @(negedge qclk);
            if (TDIN && t_in < 0) t_in = i;
            if (nxm) begin
                t_nxm = i; tsync_at = TSYNC; tsack_at = TSACK;
            end
        end
        check("nxm_latency", t_nxm - t_in, NXM_TIMEOUT);
        check("nxm_tsync_low", tsync_at, 0);
        check("nxm_tsack_low", tsack_at, 0);
        wait_idle("nxm_idle", 100);

        // RINIT during DATA of an 8-word read (slave silent)
        start(1'b0, 22'h000100, 16'd8);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge qclk);
            if (TDIN) seen = 1'b1;
        end
        check("rinit_reached_data", seen, 1);
        repeat (3) @(negedge qclk);
        RINIT = 1'b1;
        @(negedge qclk);
        RINIT = 1'b0;
        check("rinit_t_lines", {TSYNC, TDIN, TDOUT, TDMR, TSACK, TDMGO, TWTBT}, 0);
        check("rinit_busy", busy, 0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge qclk);
            if (dma_complete) seen = 1'b1;
        end
        check("rinit_no_complete", seen, 0);
        slave_en = 1'b1;
        run_xfer("after_rinit", 1'b0, 22'h000200, 2, 2);

        // Asynchronous reset mid-transfer
        slave_en = 1'b0;
        start(1'b1, 22'h000400, 16'd2);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge qclk);
            if (TSYNC) seen = 1'b1;
        end
        check("areset_reached_sync", seen, 1);
        #10;
        reset_n = 1'b0;
        #1;
        check("areset_t_lines", {TSYNC, TDIN, TDOUT, TDMR, TSACK, TDMGO, TWTBT}, 0);
        check("areset_state", {busy, assert_addr, assert_data, dma_complete}, 0);
        check("areset_cur_addr", cur_addr, 0);
        @(negedge qclk);
        reset_n = 1'b1;
        slave_en = 1'b1;
        run_xfer("after_reset", 1'b0, 22'h000600, 1, 1);

        repeat (5) @(negedge qclk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
